// File: rtl/fifo_stream_reader_if.sv
// Read-side bundle for fifo_stream_reader: FIFO pop/data return on one side,
// valid/ready stream on the other. The master modport is the reader's view;
// the slave modport is the view of whatever sits around it (FIFO + consumer).
interface fifo_stream_reader_if #(
    parameter int G_WIDTH = 8
);
    logic               o_fifo_rd;
    logic               i_fifo_empty;
    logic [G_WIDTH-1:0] i_fifo_data;
    logic               i_fifo_rd_done;
    logic               o_valid;
    logic               i_ready;
    logic [G_WIDTH-1:0] o_data;
    logic               o_last;

    modport master (
        output o_fifo_rd,
        input  i_fifo_empty,
        input  i_fifo_data,
        input  i_fifo_rd_done,
        output o_valid,
        input  i_ready,
        output o_data,
        output o_last
    );

    modport slave (
        input  o_fifo_rd,
        output i_fifo_empty,
        output i_fifo_data,
        output i_fifo_rd_done,
        input  o_valid,
        output i_ready,
        input  o_data,
        input  o_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops the synchronous FIFO, captures the returned word a
// cycle later into a small circular prefetch buffer and presents the buffer
// head as a valid/ready stream. Pop issue never looks at i_ready, so there is
// no combinational ready-to-rd path; the buffer absorbs the one-cycle return.
// Optional build macro STREAM_READER_LAST_EN adds a per-packet beat counter
// that drives o_last every G_PKT_LEN words; without it o_last is tied low.
module fifo_stream_reader #(
    parameter int G_WIDTH     = 8,
    parameter int G_BUF_DEPTH = 4,
    parameter int G_PKT_LEN   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    fifo_stream_reader_if.master bus,
    output logic [15:0]          o_word_cnt,
    output logic                 o_protocol_err
);
    localparam int PTR_W = $clog2(G_BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(G_BUF_DEPTH);

    // Elaboration-time parameter sanity.
    if (G_BUF_DEPTH < 2 || (G_BUF_DEPTH & (G_BUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_stream_reader: G_BUF_DEPTH must be a power of 2, minimum 2");
    end
    if (G_PKT_LEN < 1) begin : g_bad_pkt_len
        $error("fifo_stream_reader: G_PKT_LEN must be at least 1");
    end

    logic [G_WIDTH-1:0] buf_r [G_BUF_DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;
    logic               in_flight_r;
    logic [15:0]        word_cnt_r;
    logic               err_r;

    logic [CNT_W-1:0]   occupancy_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               in_flight_nxt_s;
    logic               rd_s;
    logic               pop_s;
    logic               full_s;
    logic               push_s;
    logic               push_drop_s;
    logic               err_set_s;

    // Occupancy counts the word still travelling back from the FIFO so a
    // returning word always has a free slot. rd is held low while in reset.
    assign occupancy_s = count_r + CNT_W'(in_flight_r);
    assign rd_s        = i_rst_n && i_en && !bus.i_fifo_empty && (occupancy_s < DEPTH_C);
    assign pop_s       = (count_r != '0) && bus.i_ready;
    assign full_s      = (count_r == DEPTH_C);
    // A full buffer can still take a word if the head leaves in the same cycle.
    assign push_s      = bus.i_fifo_rd_done && (!full_s || pop_s);
    assign push_drop_s = bus.i_fifo_rd_done && full_s && !pop_s;
    assign err_set_s   = (bus.i_fifo_rd_done && !in_flight_r) || push_drop_s;

    // Next-state for buffer count and the outstanding-read flag.
    always_comb begin
        count_nxt_s     = count_r;
        in_flight_nxt_s = in_flight_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (rd_s) begin
            in_flight_nxt_s = 1'b1;
        end else if (bus.i_fifo_rd_done) begin
            in_flight_nxt_s = 1'b0;
        end else begin
            in_flight_nxt_s = in_flight_r;
        end
    end

    // Control state: pointers, count, in-flight flag, delivered-word counter, sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            in_flight_r <= 1'b0;
            word_cnt_r  <= 16'd0;
            err_r       <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            in_flight_r <= in_flight_nxt_s;
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r     <= head_r + PTR_W'(1);
                word_cnt_r <= word_cnt_r + 16'd1;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Prefetch storage; cleared on reset so o_data reads 0 while in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < G_BUF_DEPTH; i++) begin
                buf_r[i] <= '0;
            end
        end else if (push_s) begin
            buf_r[tail_r] <= bus.i_fifo_data;
        end
    end

    assign bus.o_fifo_rd  = rd_s;
    assign bus.o_valid    = (count_r != '0);
    assign bus.o_data     = buf_r[head_r];
    assign o_word_cnt     = word_cnt_r;
    assign o_protocol_err = err_r;

`ifdef STREAM_READER_LAST_EN
    localparam int BEAT_W = $clog2(G_PKT_LEN) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(G_PKT_LEN - 1);

    logic [BEAT_W-1:0] beat_r;
    logic              last_s;

    assign last_s = (count_r != '0) && (beat_r == LAST_BEAT);

    // Beat position within the current packet; restarts after the last word is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_r <= '0;
        end else if (pop_s) begin
            if (last_s) begin
                beat_r <= '0;
            end else begin
                beat_r <= beat_r + BEAT_W'(1);
            end
        end
    end

    assign bus.o_last = last_s;
`else
    assign bus.o_last = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. A small behavioural FIFO model
// answers accepted pops with i_fifo_rd_done one cycle later; each test task
// drives its scenario and compares against hand-computed values.
module tb_fifo_stream_reader;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] word_cnt;
    logic        prot_err;

    int n_checks = 0;
    int n_errors = 0;

    fifo_stream_reader_if #(.G_WIDTH(W)) bus ();

    fifo_stream_reader #(
        .G_WIDTH    (W),
        .G_BUF_DEPTH(4),
        .G_PKT_LEN  (4)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .bus           (bus),
        .o_word_cnt    (word_cnt),
        .o_protocol_err(prot_err)
    );

    always #5 clk = ~clk;

    // FIFO model state
    logic [W-1:0] fq[$];
    bit           pend;
    logic [W-1:0] pend_data;
    bit           inject_done;
    int           pop_cnt;
    int           underflow_cnt;

    // Collected stream deliveries
    logic [W-1:0] got_q[$];
    bit           last_q[$];
    int           cyc_q[$];
    int           cyc;

    // FIFO model: updates on the falling edge, then samples the pop request
    // that the next rising edge will accept.
    initial begin
        bus.i_fifo_rd_done = 1'b0;
        bus.i_fifo_data    = 8'h00;
        bus.i_fifo_empty   = 1'b1;
        forever begin
            @(negedge clk);
            bus.i_fifo_rd_done = pend || inject_done;
            bus.i_fifo_data    = pend ? pend_data : 8'hEE;
            inject_done        = 1'b0;
            pend               = 1'b0;
            bus.i_fifo_empty   = (fq.size() == 0);
            #1;
            if (bus.o_fifo_rd === 1'b1) begin
                if (fq.size() == 0) begin
                    underflow_cnt++;
                end else begin
                    pend_data = fq.pop_front();
                    pend      = 1'b1;
                    pop_cnt++;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        bus.i_ready = 1'b0;
        fq.delete();
        pend = 1'b0;
        inject_done = 1'b0;
        pop_cnt = 0;
        underflow_cnt = 0;
        got_q.delete();
        last_q.delete();
        cyc_q.delete();
        cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run n cycles, recording each word that is handed over at the coming edge.
    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
                got_q.push_back(bus.o_data);
                last_q.push_back(bus.o_last);
                cyc_q.push_back(cyc);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        bus.i_ready = 1'b1;
        fq.delete();
        fq.push_back(8'hA5);
        pend = 1'b0;
        inject_done = 1'b0;
        pop_cnt = 0;
        underflow_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.o_fifo_rd !== 1'b0) begin n_errors++; $display("FAIL reset_rd: got %b expected 0", bus.o_fifo_rd); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_last !== 1'b0) begin n_errors++; $display("FAIL reset_last: got %b expected 0", bus.o_last); end
        n_checks++; if (bus.o_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h expected 00", bus.o_data); end
        n_checks++; if (word_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
        n_checks++; if (prot_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", prot_err); end
        n_checks++; if (pop_cnt !== 0) begin n_errors++; $display("FAIL reset_pops: got %0d expected 0", pop_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] exp_q[$] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        bus.i_ready = 1'b1;
        en = 1'b1;
        collect(10);
        n_checks++; if (pop_cnt !== 3) begin n_errors++; $display("FAIL basic_pops: got %0d expected 3", pop_cnt); end
        n_checks++; if (got_q.size() !== 3) begin n_errors++; $display("FAIL basic_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL basic_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (cyc_q[0] !== 2) begin n_errors++; $display("FAIL basic_latency: got cycle %0d expected 2", cyc_q[0]); end
        n_checks++; if (cyc_q[2] - cyc_q[0] !== 2) begin n_errors++; $display("FAIL basic_back_to_back: got span %0d expected 2", cyc_q[2] - cyc_q[0]); end
        n_checks++; if (word_cnt !== 16'd3) begin n_errors++; $display("FAIL basic_word_cnt: got %0d expected 3", word_cnt); end
        n_checks++; if (underflow_cnt !== 0) begin n_errors++; $display("FAIL basic_underflow: got %0d expected 0", underflow_cnt); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain: got valid %b expected 0", bus.o_valid); end
    endtask

    task automatic test_backpressure();
        int  unstable = 0;
        bit  seen = 1'b0;
        int  max_gap = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            fq.push_back(8'(8'h30 + i));
        end
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (bus.o_valid === 1'b1) seen = 1'b1;
            if (seen && (bus.o_valid !== 1'b1 || bus.o_data !== 8'h30)) unstable++;
        end
        n_checks++; if (pop_cnt !== 4) begin n_errors++; $display("FAIL bp_pops: got %0d expected 4", pop_cnt); end
        n_checks++; if (bus.o_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b expected 1", bus.o_valid); end
        n_checks++; if (bus.o_data !== 8'h30) begin n_errors++; $display("FAIL bp_data: got %h expected 30", bus.o_data); end
        n_checks++; if (unstable !== 0) begin n_errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", unstable); end
        n_checks++; if (prot_err !== 1'b0) begin n_errors++; $display("FAIL bp_err: got %b expected 0", prot_err); end
        bus.i_ready = 1'b1;
        cyc = 0;
        collect(20);
        n_checks++; if (got_q.size() !== 10) begin n_errors++; $display("FAIL bp_count: got %0d expected 10", got_q.size()); end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (got_q[i] !== 8'(8'h30 + i)) begin n_errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], 8'(8'h30 + i)); end
        end
        for (int i = 1; i < cyc_q.size(); i++) begin
            if (cyc_q[i] - cyc_q[i-1] > max_gap) max_gap = cyc_q[i] - cyc_q[i-1];
        end
        n_checks++; if (max_gap > 2) begin n_errors++; $display("FAIL bp_gap: got step %0d expected at most 2", max_gap); end
        n_checks++; if (word_cnt !== 16'd10) begin n_errors++; $display("FAIL bp_word_cnt: got %0d expected 10", word_cnt); end
        n_checks++; if (underflow_cnt !== 0) begin n_errors++; $display("FAIL bp_underflow: got %0d expected 0", underflow_cnt); end
    endtask

    task automatic test_en_drop();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fq.push_back(8'(8'h51 + i));
        end
        bus.i_ready = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        collect(8);
        n_checks++; if (pop_cnt !== 1) begin n_errors++; $display("FAIL en_pops: got %0d expected 1", pop_cnt); end
        n_checks++; if (got_q.size() !== 1) begin n_errors++; $display("FAIL en_count: got %0d expected 1", got_q.size()); end
        n_checks++; if (got_q[0] !== 8'h51) begin n_errors++; $display("FAIL en_data: got %h expected 51", got_q[0]); end
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL en_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (word_cnt !== 16'd1) begin n_errors++; $display("FAIL en_word_cnt: got %0d expected 1", word_cnt); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        @(posedge clk);
        #1;
        n_checks++; if (prot_err !== 1'b0) begin n_errors++; $display("FAIL perr_idle: got %b expected 0", prot_err); end
        inject_done = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (prot_err !== 1'b1) begin n_errors++; $display("FAIL perr_set: got %b expected 1", prot_err); end
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (prot_err !== 1'b1) begin n_errors++; $display("FAIL perr_sticky: got %b expected 1", prot_err); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (prot_err !== 1'b0) begin n_errors++; $display("FAIL perr_clear: got %b expected 0", prot_err); end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fq.push_back(8'(8'h60 + i));
        end
        en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (prot_err !== 1'b0) begin n_errors++; $display("FAIL full_no_err: got %b expected 0", prot_err); end
        inject_done = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (prot_err !== 1'b1) begin n_errors++; $display("FAIL full_err: got %b expected 1", prot_err); end
        bus.i_ready = 1'b1;
        collect(8);
        n_checks++; if (got_q.size() !== 4) begin n_errors++; $display("FAIL full_count: got %0d expected 4", got_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (got_q[i] !== 8'(8'h60 + i)) begin n_errors++; $display("FAIL full_data[%0d]: got %h expected %h", i, got_q[i], 8'(8'h60 + i)); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fq.push_back(8'(8'h71 + i));
        end
        en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++; if (pop_cnt !== 4) begin n_errors++; $display("FAIL ar_pops: got %0d expected 4", pop_cnt); end
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        n_checks++; if (word_cnt !== 16'd1) begin n_errors++; $display("FAIL ar_word_cnt: got %0d expected 1", word_cnt); end
        n_checks++; if (bus.o_fifo_rd !== 1'b1) begin n_errors++; $display("FAIL ar_rd_before: got %b expected 1", bus.o_fifo_rd); end
        n_checks++; if (bus.o_data !== 8'h72) begin n_errors++; $display("FAIL ar_data_before: got %h expected 72", bus.o_data); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_errors++; $display("FAIL ar_valid: got %b expected 0", bus.o_valid); end
        n_checks++; if (bus.o_fifo_rd !== 1'b0) begin n_errors++; $display("FAIL ar_rd: got %b expected 0", bus.o_fifo_rd); end
        n_checks++; if (word_cnt !== 16'd0) begin n_errors++; $display("FAIL ar_word_cnt_clr: got %0d expected 0", word_cnt); end
    endtask

    task automatic test_last();
        bit exp_last;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            fq.push_back(8'(8'h81 + i));
        end
        bus.i_ready = 1'b1;
        en = 1'b1;
        collect(16);
        n_checks++; if (got_q.size() !== 8) begin n_errors++; $display("FAIL last_count: got %0d expected 8", got_q.size()); end
        for (int i = 0; i < 8; i++) begin
`ifdef STREAM_READER_LAST_EN
            exp_last = ((i % 4) == 3);
`else
            exp_last = 1'b0;
`endif
            n_checks++; if (last_q[i] !== exp_last) begin n_errors++; $display("FAIL last_flag[%0d]: got %b expected %b", i, last_q[i], exp_last); end
        end
        n_checks++; if (word_cnt !== 16'd8) begin n_errors++; $display("FAIL last_word_cnt: got %0d expected 8", word_cnt); end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        bus.i_ready = 1'b0;
        pend = 1'b0;
        inject_done = 1'b0;
        pend_data = 8'h00;
        cyc = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_en_drop();
        test_protocol_err();
        test_full_drop();
        test_async_reset();
        test_last();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
